rf_wb_ctrl: RTL and testbench

RF_WB_CTRL -- requirements
Module: rf_wb_ctrl

---
 rtl/rf_wb_ctrl.sv | 152 +++++++++++++++
 tb/tb_rf_wb_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_ctrl.sv
// rtl/rf_wb_ctrl.sv - register-file writeback arbiter with LSU FIFO and load scoreboard
module rf_wb_ctrl #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          alu_we_i,
  input  logic [AW-1:0] alu_addr_i,
  input  logic [DW-1:0] alu_data_i,
  input  logic          lsu_valid_i,
  output logic          lsu_ready_o,
  input  logic [AW-1:0] lsu_addr_i,
  input  logic [DW-1:0] lsu_data_i,
  input  logic          issue_i,
  input  logic [AW-1:0] issue_addr_i,
  output logic          rf_we_o,
  output logic [AW-1:0] rf_waddr_o,
  output logic [DW-1:0] rf_wdata_o,
  output logic [31:0]   pending_o,
  output logic [2:0]    fifo_count_o
);

  localparam int         PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0] DEPTH_C = 3'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  // FIFO storage and bookkeeping
  logic [AW-1:0] fifo_addr_q [DEPTH];
  logic [DW-1:0] fifo_data_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [2:0]    count_q;

  // Scoreboard and registered write port
  logic [31:0]   pending_q;
  logic          rf_we_q;
  logic [AW-1:0] rf_waddr_q;
  logic [DW-1:0] rf_wdata_q;

  // Per-cycle decisions
  logic          push;
  logic          pop;
  logic          alu_sel;
  logic          fifo_empty;
  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_data;
  logic          we_d;
  logic [AW-1:0] waddr_d;
  logic [DW-1:0] wdata_d;
  logic [31:0]   set_mask;
  logic [31:0]   clr_mask;
  logic [31:0]   pending_d;
  logic [PW-1:0] wr_ptr_inc;
  logic [PW-1:0] rd_ptr_inc;

  // Ready is gated by reset so an LSU offer is never taken while the block is held in reset.
  assign lsu_ready_o = rst_ni && (count_q < DEPTH_C);
  assign push        = lsu_valid_i && lsu_ready_o;
  assign fifo_empty  = (count_q == 3'd0);
  assign alu_sel     = alu_we_i && (alu_addr_i != '0);
  // A discarded x0 ALU request does not steal the port from the FIFO.
  assign pop         = !alu_sel && !fifo_empty;
  assign head_addr   = fifo_addr_q[rd_ptr_q];
  assign head_data   = fifo_data_q[rd_ptr_q];

  // Pointers wrap explicitly so non-power-of-two depths also work.
  assign wr_ptr_inc = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
  assign rd_ptr_inc = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;

  // Select the write for the next edge: ALU first, then FIFO head; x0 targets never write.
  always_comb begin
    we_d    = 1'b0;
    waddr_d = rf_waddr_q;
    wdata_d = rf_wdata_q;
    if (alu_sel) begin
      we_d    = 1'b1;
      waddr_d = alu_addr_i;
      wdata_d = alu_data_i;
    end else if (pop && (head_addr != '0)) begin
      we_d    = 1'b1;
      waddr_d = head_addr;
      wdata_d = head_data;
    end
  end

  // Scoreboard update: clear on pop, set on issue, set applied last so it wins a same-register race.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (issue_i && (issue_addr_i != '0)) begin
      set_mask = 32'd1 << issue_addr_i;
    end
    if (pop && (head_addr != '0)) begin
      clr_mask = 32'd1 << head_addr;
    end
    pending_d = ((pending_q & ~clr_mask) | set_mask) & ~32'd1;
  end

  // FIFO pointers, occupancy and entry storage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= 3'd0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_addr_q[i] <= '0;
        fifo_data_q[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_addr_q[wr_ptr_q] <= lsu_addr_i;
        fifo_data_q[wr_ptr_q] <= lsu_data_i;
        wr_ptr_q              <= wr_ptr_inc;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_inc;
      end
      count_q <= count_q + 3'(push) - 3'(pop);
    end
  end

  // Registered write port; address and data hold when nothing is written.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rf_we_q    <= we_d;
      rf_waddr_q <= waddr_d;
      rf_wdata_q <= wdata_d;
    end
  end

  // Outstanding-load scoreboard register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign rf_we_o      = rf_we_q;
  assign rf_waddr_o   = rf_waddr_q;
  assign rf_wdata_o   = rf_wdata_q;
  assign pending_o    = pending_q;
  assign fifo_count_o = count_q;

endmodule

// File: tb/tb_rf_wb_ctrl.sv
// tb/tb_rf_wb_ctrl.sv - self-checking bench for rf_wb_ctrl
module tb_rf_wb_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        alu_we_i;
  logic [4:0]  alu_addr_i;
  logic [31:0] alu_data_i;
  logic        lsu_valid_i;
  logic        lsu_ready_o;
  logic [4:0]  lsu_addr_i;
  logic [31:0] lsu_data_i;
  logic        issue_i;
  logic [4:0]  issue_addr_i;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic [31:0] pending_o;
  logic [2:0]  fifo_count_o;

  int tests = 0;
  int fails = 0;

  rf_wb_ctrl #(.DEPTH(4), .AW(5), .DW(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .alu_we_i(alu_we_i), .alu_addr_i(alu_addr_i), .alu_data_i(alu_data_i),
    .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o),
    .lsu_addr_i(lsu_addr_i), .lsu_data_i(lsu_data_i),
    .issue_i(issue_i), .issue_addr_i(issue_addr_i),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .pending_o(pending_o), .fifo_count_o(fifo_count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        alu_we;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        lsu_valid;
    logic [4:0]  lsu_addr;
    logic [31:0] lsu_data;
    logic        issue;
    logic [4:0]  issue_addr;
    logic        exp_we;
    logic [4:0]  exp_waddr;
    logic [31:0] exp_wdata;
    logic [31:0] exp_pend;
    logic [2:0]  exp_cnt;
  } vec_t;

  vec_t vt[15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    alu_we_i = 0; alu_addr_i = 0; alu_data_i = 0;
    lsu_valid_i = 0; lsu_addr_i = 0; lsu_data_i = 0;
    issue_i = 0; issue_addr_i = 0;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_ni = 0;
    step();
    step();
    #2 rst_ni = 1;
    step();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".we"},    64'(rf_we_o),      64'd0);
    chk({tag, ".waddr"}, 64'(rf_waddr_o),   64'd0);
    chk({tag, ".wdata"}, 64'(rf_wdata_o),   64'd0);
    chk({tag, ".pend"},  64'(pending_o),    64'd0);
    chk({tag, ".cnt"},   64'(fifo_count_o), 64'd0);
    chk({tag, ".ready"}, 64'(lsu_ready_o),  64'd0);
  endtask

  // Reference model state: FIFO as a queue of {addr,data}, scoreboard as a bit array.
  logic [36:0] mq[$];
  logic        m_pend[32];
  logic        m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;

  function automatic logic [31:0] m_pend_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_pend[i];
    return v;
  endfunction

  // Advance the model by one clock edge using the current inputs.
  function automatic void model_edge();
    logic [36:0] e;
    bit ready;
    ready = (mq.size() < 4);
    m_we = 0;
    if (alu_we_i && alu_addr_i != 0) begin
      m_we = 1; m_waddr = alu_addr_i; m_wdata = alu_data_i;
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      if (e[36:32] != 0) begin
        m_we = 1; m_waddr = e[36:32]; m_wdata = e[31:0];
        m_pend[e[36:32]] = 0;
      end
    end
    if (lsu_valid_i && ready) mq.push_back({lsu_addr_i, lsu_data_i});
    if (issue_i && issue_addr_i != 0) m_pend[issue_addr_i] = 1;
  endfunction

  function automatic vec_t mk(
      logic aw, logic [4:0] aa, logic [31:0] ad,
      logic lv, logic [4:0] la, logic [31:0] ld,
      logic is, logic [4:0] ia,
      logic ew, logic [4:0] ea, logic [31:0] ed, logic [31:0] ep, logic [2:0] ec);
    vec_t v;
    v.alu_we = aw; v.alu_addr = aa; v.alu_data = ad;
    v.lsu_valid = lv; v.lsu_addr = la; v.lsu_data = ld;
    v.issue = is; v.issue_addr = ia;
    v.exp_we = ew; v.exp_waddr = ea; v.exp_wdata = ed; v.exp_pend = ep; v.exp_cnt = ec;
    return v;
  endfunction

  initial begin
    int n;
    logic        hv;
    logic [4:0]  ha;
    logic [31:0] hd;
    bit          ready_m;

    // Directed single-cycle vectors, applied straight after reset.
    vt[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0,  1, 5, 32'hDEADBEEF, 32'h0,  3'd0);
    vt[1]  = mk(0, 0, 0,            0, 0, 0, 0, 0,  0, 5, 32'hDEADBEEF, 32'h0,  3'd0);
    vt[2]  = mk(0, 0, 0,            0, 0, 0, 1, 7,  0, 5, 32'hDEADBEEF, 32'h80, 3'd0);
    vt[3]  = mk(0, 0, 0,            1, 7, 32'h12345678, 0, 0, 0, 5, 32'hDEADBEEF, 32'h80, 3'd1);
    vt[4]  = mk(0, 0, 0,            0, 0, 0, 0, 0,  1, 7, 32'h12345678, 32'h0,  3'd0);
    vt[5]  = mk(0, 0, 0,            0, 0, 0, 0, 0,  0, 7, 32'h12345678, 32'h0,  3'd0);
    vt[6]  = mk(1, 3, 32'h33,       1, 9, 32'h99, 0, 0, 1, 3, 32'h33, 32'h0, 3'd1);
    vt[7]  = mk(1, 0, 32'hBAD,      0, 0, 0, 0, 0,  1, 9, 32'h99, 32'h0, 3'd0);
    vt[8]  = mk(0, 0, 0,            1, 0, 32'h55, 0, 0, 0, 9, 32'h99, 32'h0, 3'd1);
    vt[9]  = mk(0, 0, 0,            0, 0, 0, 0, 0,  0, 9, 32'h99, 32'h0, 3'd0);
    vt[10] = mk(0, 0, 0,            0, 0, 0, 1, 0,  0, 9, 32'h99, 32'h0, 3'd0);
    vt[11] = mk(0, 0, 0,            0, 0, 0, 1, 4,  0, 9, 32'h99, 32'h10, 3'd0);
    vt[12] = mk(0, 0, 0,            1, 4, 32'h44, 0, 0, 0, 9, 32'h99, 32'h10, 3'd1);
    vt[13] = mk(0, 0, 0,            0, 0, 0, 1, 4,  1, 4, 32'h44, 32'h10, 3'd0);
    vt[14] = mk(0, 0, 0,            0, 0, 0, 0, 0,  0, 4, 32'h44, 32'h10, 3'd0);

    // Reset state is forced without any clock edge.
    idle();
    rst_ni = 0;
    #1;
    chk_all_zero("reset");
    do_reset();
    chk("post_reset.ready", 64'(lsu_ready_o), 64'd1);

    for (int i = 0; i < 15; i++) begin
      alu_we_i = vt[i].alu_we; alu_addr_i = vt[i].alu_addr; alu_data_i = vt[i].alu_data;
      lsu_valid_i = vt[i].lsu_valid; lsu_addr_i = vt[i].lsu_addr; lsu_data_i = vt[i].lsu_data;
      issue_i = vt[i].issue; issue_addr_i = vt[i].issue_addr;
      step();
      chk($sformatf("vec%0d.we", i),    64'(rf_we_o),      64'(vt[i].exp_we));
      chk($sformatf("vec%0d.waddr", i), 64'(rf_waddr_o),   64'(vt[i].exp_waddr));
      chk($sformatf("vec%0d.wdata", i), 64'(rf_wdata_o),   64'(vt[i].exp_wdata));
      chk($sformatf("vec%0d.pend", i),  64'(pending_o),    64'(vt[i].exp_pend));
      chk($sformatf("vec%0d.cnt", i),   64'(fifo_count_o), 64'(vt[i].exp_cnt));
    end
    idle();

    // ALU starves the FIFO: five offers, four taken, fifth held back.
    do_reset();
    n = 0;
    alu_we_i = 1; alu_addr_i = 3; alu_data_i = 32'hA1;
    for (int c = 0; c < 6; c++) begin
      lsu_valid_i = (n < 5);
      lsu_addr_i = 5'(10 + n);
      lsu_data_i = 32'h100 + n;
      #0;
      if (lsu_ready_o && lsu_valid_i) n++;
      step();
      chk($sformatf("starve%0d.alu_we", c), 64'(rf_we_o), 64'd1);
      chk($sformatf("starve%0d.alu_addr", c), 64'(rf_waddr_o), 64'd3);
    end
    chk("full.accepted", 64'(n), 64'd4);
    chk("full.cnt", 64'(fifo_count_o), 64'd4);
    chk("full.ready", 64'(lsu_ready_o), 64'd0);
    idle();
    for (int c = 0; c < 4; c++) begin
      step();
      chk($sformatf("drain%0d.we", c),    64'(rf_we_o),    64'd1);
      chk($sformatf("drain%0d.waddr", c), 64'(rf_waddr_o), 64'(10 + c));
      chk($sformatf("drain%0d.wdata", c), 64'(rf_wdata_o), 64'(32'h100 + c));
    end
    chk("drain.cnt", 64'(fifo_count_o), 64'd0);
    step();
    chk("drain.idle_we", 64'(rf_we_o), 64'd0);

    // Asynchronous reset mid-operation with three buffered entries and pending 0x90.
    alu_we_i = 1; alu_addr_i = 3; alu_data_i = 32'h1;
    lsu_valid_i = 1; lsu_addr_i = 4; lsu_data_i = 32'h4; issue_i = 1; issue_addr_i = 4;
    step();
    lsu_addr_i = 7; lsu_data_i = 32'h7; issue_addr_i = 7;
    step();
    lsu_addr_i = 9; lsu_data_i = 32'h9; issue_i = 0;
    step();
    idle();
    chk("pre_rst.cnt",  64'(fifo_count_o), 64'd3);
    chk("pre_rst.pend", 64'(pending_o),    64'h90);
    #2 rst_ni = 0;
    #1;
    chk_all_zero("async_rst");
    #4 rst_ni = 1;
    for (int c = 0; c < 6; c++) begin
      step();
      chk($sformatf("after_rst%0d.we", c),  64'(rf_we_o),      64'd0);
      chk($sformatf("after_rst%0d.cnt", c), 64'(fifo_count_o), 64'd0);
    end

    // Randomised traffic against the queue-based model.
    do_reset();
    mq.delete();
    for (int i = 0; i < 32; i++) m_pend[i] = 0;
    m_we = 0; m_waddr = 0; m_wdata = 0;
    hv = 0; ha = 0; hd = 0;
    for (int c = 0; c < 3000; c++) begin
      int alu_pct;
      alu_pct = ((c / 150) % 2) ? 92 : 30;
      alu_we_i = ($urandom_range(99) < alu_pct);
      alu_addr_i = ($urandom_range(9) == 0) ? 5'd0 : 5'($urandom_range(31));
      alu_data_i = $urandom;
      if (!hv) begin
        hv = ($urandom_range(99) < 60);
        ha = ($urandom_range(9) == 0) ? 5'd0 : 5'($urandom_range(31));
        hd = $urandom;
      end
      lsu_valid_i = hv; lsu_addr_i = ha; lsu_data_i = hd;
      issue_i = ($urandom_range(99) < 30);
      issue_addr_i = 5'($urandom_range(31));
      ready_m = (mq.size() < 4);
      #0;
      chk("rnd.ready", 64'(lsu_ready_o), 64'(ready_m));
      if (hv && ready_m) hv = 0;
      model_edge();
      step();
      chk("rnd.we", 64'(rf_we_o), 64'(m_we));
      chk("rnd.waddr", 64'(rf_waddr_o), 64'(m_waddr));
      chk("rnd.wdata", 64'(rf_wdata_o), 64'(m_wdata));
      chk("rnd.pend", 64'(pending_o), 64'(m_pend_vec()));
      chk("rnd.cnt", 64'(fifo_count_o), 64'(mq.size()));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
